bios_boot_watchdog: RTL and testbench
=====================================

Name: bios_boot_watchdog

Overview:
- Generates `Active_Bios` and `Next_Bios` for the dual-socket BIOS chip-select logic, and consumes the `Next_Bios_latch` that the chip-select logic returns.
- Times each host boot from PCI reset release until firmware reports POST complete.
- On timeout, switches to the other BIOS socket and requests a host reset; if both sockets fail, it gives up.
- Sits in ODS_MR beside the BIOS chip-select control, clocked from the CPLD system clock.

Parameters:
- CLK_PER_TICK, 3300000: Clk cycles per 100 ms timer tick (33 MHz clock).
- BOOT_TIMEOUT, 1500: boot timeout in ticks (150 s); range 1..65535.
- MAX_SWITCH, 1: number of socket switches allowed per power cycle; range 1..3.
- RST_PULSE, 1024: width of the `Host_Rst_Req` pulse, in Clk cycles.

Ports:
- Clk, input, 1: system clock.
- Reset, input, 1: synchronous reset, active high.
- Pwr_ok, input, 1: main power good; already synchronised to Clk.
- PciReset, input, 1: 1 = host out of PCI reset (running), 0 = in reset; already synchronised.
- Next_Bios_latch, input, 1: socket number latched by the chip-select logic at reset release.
- Bios_Done, input, 1: one-Clk strobe from the LPC register block meaning POST complete.
- Sw_Sel_Wr, input, 1: one-Clk strobe that writes a software next-BIOS request.
- Sw_Sel, input, 1: requested socket, qualified by `Sw_Sel_Wr`.
- Wdt_En, input, 1: 1 = watchdog armed; 0 = timer held at 0, no failover.
- Active_Bios, output, 1: socket currently selected for the SPI chip select.
- Next_Bios, output, 1: socket to be used after the next PCI reset.
- Host_Rst_Req, output, 1: active-high pulse requesting a host reset.
- Boot_Fail, output, 2: sticky per-socket timeout flags; bit n set = socket n timed out.
- Wdt_State, output, 3: current FSM state encoding, for the status register.

Behaviour:
Reset:
- Reset and the `Pwr_ok` = 0 state both produce the same values: `Active_Bios`=0, `Next_Bios`=0, `Host_Rst_Req`=0, `Boot_Fail`=2'b00, switch count 0, timer 0, state OFF.
- Exception: `Pwr_ok` low does not clear `Boot_Fail`; only Reset clears it.
- All outputs are registered.

States (encoding): OFF=0, HOLD=1, BOOT=2, DONE=3, SWITCH=4, DEAD=5.

Transitions (from every state, `Pwr_ok`=0 goes to OFF on the next Clk):
- OFF -> HOLD when `Pwr_ok`=1.
- HOLD:
  - On PciReset 0->1, load `Active_Bios` <= `Next_Bios_latch`, clear the timer, go to BOOT.
  - `Next_Bios_latch` is sampled one Clk after the rising edge, so the latch has settled.
- BOOT:
  - While `Wdt_En`=1, the timer increments once per tick.
  - `Bios_Done` -> DONE; the timer freezes.
  - Timer reaching BOOT_TIMEOUT -> set `Boot_Fail[Active_Bios]`, then:
    - switch count < MAX_SWITCH: go to SWITCH;
    - otherwise: go to DEAD.
  - PciReset falling before done or timeout -> HOLD; this is a warm reset, with no failure recorded.
  - `Bios_Done` and timeout in the same Clk: `Bios_Done` wins.
- DONE:
  - Stays until PciReset falls, then goes to HOLD.
  - A `Bios_Done` repeated in DONE is ignored.
- SWITCH:
  - `Next_Bios` <= ~`Active_Bios`; switch count +1.
  - `Host_Rst_Req`=1 for exactly RST_PULSE cycles, then go to HOLD.
- DEAD:
  - `Host_Rst_Req`=0; no further switching until `Pwr_ok` cycles.
  - PciReset edges still update `Active_Bios` through HOLD/BOOT semantics, but the timer stays disabled.

Tick prescaler:
- Free-runs 0..CLK_PER_TICK-1; a tick fires on wrap.
- Cleared on entry to BOOT, so the first tick is a full period.

Timer and switch counter:
- Timer is 16 bits and saturates, never wraps.
- The switch counter is not reset by PciReset; it is reset only by `Pwr_ok` low or Reset.

Software select:
- `Sw_Sel_Wr` sets `Next_Bios` <= `Sw_Sel` in any state except SWITCH and DEAD.
- If `Sw_Sel_Wr` coincides with SWITCH entry, the failover value wins.

Tick gating:
- `Wdt_En` dropping mid-BOOT freezes and clears the timer; re-enabling restarts the count from 0.

Decomposition:
- Package `bios_wdt_pkg` holds:
  - the state encoding constants;
  - the timer width (16) and switch-count width (2);
  - default values for CLK_PER_TICK and BOOT_TIMEOUT.
- One sub-module, `tick_prescaler`, implements the parameterised divider with a synchronous clear and a one-Clk tick output.
- The FSM, timer, and `Next_Bios`/`Active_Bios` registers stay in the top module.

Test Plan:
Benches override CLK_PER_TICK=4, BOOT_TIMEOUT=10, RST_PULSE=8.
1. Reset, `Pwr_ok`=1, `Next_Bios_latch`=0, PciReset rise, `Bios_Done` after 5 ticks -> state DONE, `Active_Bios`=0, `Boot_Fail`=00, `Host_Rst_Req` never asserts.
2. Same setup, no `Bios_Done` -> at tick 10, `Boot_Fail`=01 and state SWITCH; `Next_Bios`=1; `Host_Rst_Req` high for exactly 8 Clk; then HOLD. After PciReset fall and rise with latch=1 -> `Active_Bios`=1.
3. Continue scenario 2 with no `Bios_Done` on socket 1 -> `Boot_Fail`=11, state DEAD, no second `Host_Rst_Req`. `Pwr_ok` low then high -> state OFF then HOLD, switch count 0, `Boot_Fail` still 11.
4. In BOOT at timer=10, `Bios_Done` in the same Clk as the timeout -> DONE, `Boot_Fail` unchanged, no reset request.
5. PciReset falls at tick 6 of BOOT -> HOLD, no flag set; after the next rise, the timer restarts from 0 and times out at tick 10.
6. `Sw_Sel_Wr` with `Sw_Sel`=1 in HOLD -> `Next_Bios`=1 the next Clk. `Wdt_En`=0 during BOOT for 20 ticks -> no timeout and timer=0.

Source files
------------

// File: rtl/bios_wdt_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bios_wdt_pkg
// Shared definitions for the BIOS boot watchdog: FSM state encoding (also
// exported through the status register), counter widths, default timing
// values and a saturating increment helper for the boot timer.
// -----------------------------------------------------------------------------
package bios_wdt_pkg;

  localparam int TIMER_W          = 16;
  localparam int SWCNT_W          = 2;
  localparam int DEF_CLK_PER_TICK = 3300000;
  localparam int DEF_BOOT_TIMEOUT = 1500;

  // Encoding is visible to software through Wdt_State; do not renumber.
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_HOLD   = 3'd1,
    ST_BOOT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_SWITCH = 3'd4,
    ST_DEAD   = 3'd5
  } wdt_state_e;

  // Timer counts up and sticks at all-ones instead of wrapping back to zero.
  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    if (v == {TIMER_W{1'b1}}) begin
      return v;
    end else begin
      return v + TIMER_W'(1);
    end
  endfunction

endpackage

// File: rtl/bios_boot_watchdog_tick_prescaler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider counting 0..CLK_PER_TICK-1. A registered one-cycle
// tick follows every wrap. A synchronous clear restarts the period so the
// first tick after a clear is a full period away.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active high
//   clr  - synchronous restart of the period, active high
//   tick - one-cycle strobe, once per CLK_PER_TICK cycles
// -----------------------------------------------------------------------------
module tick_prescaler
  import bios_wdt_pkg::*;
#(
  parameter int CLK_PER_TICK = DEF_CLK_PER_TICK
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W    = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_TICK - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // Divider counter and registered wrap strobe.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/bios_boot_watchdog.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bios_boot_watchdog
// Times each host boot from PCI reset release to POST complete. On timeout it
// marks the failing socket, points Next_Bios at the other socket and pulses
// a host reset request; once the switch budget is spent it parks in DEAD
// until power cycles.
// Ports:
//   Clk, Reset       - system clock, synchronous active-high reset
//   Pwr_ok           - main power good (synchronised); low forces OFF
//   PciReset         - 1 = host running, 0 = host held in PCI reset
//   Next_Bios_latch  - socket captured by chip-select logic at reset release
//   Bios_Done        - one-cycle POST-complete strobe
//   Sw_Sel_Wr/Sw_Sel - software write of the next socket
//   Wdt_En           - watchdog arm; low keeps the boot timer at zero
//   Active_Bios      - socket currently driving the SPI chip select
//   Next_Bios        - socket to use after the next PCI reset
//   Host_Rst_Req     - host reset request pulse
//   Boot_Fail        - sticky per-socket timeout flags
//   Wdt_State        - FSM state for the status register
// -----------------------------------------------------------------------------
module bios_boot_watchdog
  import bios_wdt_pkg::*;
#(
  parameter int CLK_PER_TICK = DEF_CLK_PER_TICK,
  parameter int BOOT_TIMEOUT = DEF_BOOT_TIMEOUT,
  parameter int MAX_SWITCH   = 1,
  parameter int RST_PULSE    = 1024
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Pwr_ok,
  input  logic       PciReset,
  input  logic       Next_Bios_latch,
  input  logic       Bios_Done,
  input  logic       Sw_Sel_Wr,
  input  logic       Sw_Sel,
  input  logic       Wdt_En,
  output logic       Active_Bios,
  output logic       Next_Bios,
  output logic       Host_Rst_Req,
  output logic [1:0] Boot_Fail,
  output logic [2:0] Wdt_State
);

  localparam int                 PULSE_W     = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PULSE_W-1:0] PULSE_LAST  = PULSE_W'(RST_PULSE - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(BOOT_TIMEOUT);
  localparam logic [SWCNT_W-1:0] SWCNT_MAX   = SWCNT_W'(MAX_SWITCH);

  wdt_state_e         state_r, state_s;
  logic               active_r, active_s;
  logic               next_r, next_s;
  logic [1:0]         fail_r, fail_s;
  logic [SWCNT_W-1:0] swcnt_r, swcnt_s;
  logic [TIMER_W-1:0] timer_r, timer_s;
  logic [PULSE_W-1:0] pulse_r, pulse_s;
  logic               host_r;
  logic               pci_q_r;
  logic               rise_d_r;
  logic               clr_s;
  logic               tick_s;
  logic               timeout_s;

  tick_prescaler #(
    .CLK_PER_TICK (CLK_PER_TICK)
  ) u_prescaler (
    .clk  (Clk),
    .rst  (Reset),
    .clr  (clr_s),
    .tick (tick_s)
  );

  assign timeout_s = Wdt_En && (timer_r >= TIMEOUT_VAL);

  // Next-state and next-register-value logic for the watchdog FSM.
  always_comb begin
    state_s  = state_r;
    active_s = active_r;
    fail_s   = fail_r;
    swcnt_s  = swcnt_r;
    timer_s  = timer_r;
    pulse_s  = pulse_r;
    clr_s    = 1'b0;
    // Software select first; a failover below overrides it on SWITCH entry.
    if (Sw_Sel_Wr && (state_r != ST_SWITCH) && (state_r != ST_DEAD)) begin
      next_s = Sw_Sel;
    end else begin
      next_s = next_r;
    end

    if (!Pwr_ok) begin
      state_s  = ST_OFF;
      active_s = 1'b0;
      next_s   = 1'b0;
      swcnt_s  = {SWCNT_W{1'b0}};
      timer_s  = {TIMER_W{1'b0}};
      pulse_s  = {PULSE_W{1'b0}};
    end else begin
      case (state_r)
        ST_OFF: begin
          state_s = ST_HOLD;
        end
        ST_HOLD: begin
          // rise_d_r is one cycle after the PciReset edge, so the latch has settled.
          if (rise_d_r) begin
            state_s  = ST_BOOT;
            active_s = Next_Bios_latch;
            timer_s  = {TIMER_W{1'b0}};
            clr_s    = 1'b1;
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_BOOT: begin
          if (!Wdt_En) begin
            timer_s = {TIMER_W{1'b0}};
          end else if (tick_s) begin
            timer_s = sat_inc(timer_r);
          end else begin
            timer_s = timer_r;
          end
          // POST complete beats a timeout seen in the same cycle.
          if (Bios_Done) begin
            state_s = ST_DONE;
          end else if (timeout_s) begin
            fail_s[active_r] = 1'b1;
            if (swcnt_r < SWCNT_MAX) begin
              state_s = ST_SWITCH;
              next_s  = ~active_r;
              swcnt_s = swcnt_r + SWCNT_W'(1);
              pulse_s = {PULSE_W{1'b0}};
            end else begin
              state_s = ST_DEAD;
            end
          end else if (!PciReset) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_BOOT;
          end
        end
        ST_DONE: begin
          if (!PciReset) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_DONE;
          end
        end
        ST_SWITCH: begin
          if (pulse_r == PULSE_LAST) begin
            state_s = ST_HOLD;
            pulse_s = {PULSE_W{1'b0}};
          end else begin
            state_s = ST_SWITCH;
            pulse_s = pulse_r + PULSE_W'(1);
          end
        end
        ST_DEAD: begin
          // Socket still follows the chip-select latch, but no timing here.
          if (rise_d_r) begin
            active_s = Next_Bios_latch;
          end else begin
            active_s = active_r;
          end
        end
        default: begin
          state_s = ST_OFF;
        end
      endcase
    end
  end

  // State and output registers; Boot_Fail survives power loss, only Reset clears it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r  <= ST_OFF;
      active_r <= 1'b0;
      next_r   <= 1'b0;
      fail_r   <= 2'b00;
      swcnt_r  <= {SWCNT_W{1'b0}};
      timer_r  <= {TIMER_W{1'b0}};
      pulse_r  <= {PULSE_W{1'b0}};
      host_r   <= 1'b0;
      pci_q_r  <= 1'b0;
      rise_d_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      active_r <= active_s;
      next_r   <= next_s;
      fail_r   <= fail_s;
      swcnt_r  <= swcnt_s;
      timer_r  <= timer_s;
      pulse_r  <= pulse_s;
      host_r   <= (state_s == ST_SWITCH);
      pci_q_r  <= PciReset;
      rise_d_r <= PciReset & ~pci_q_r;
    end
  end

  assign Active_Bios  = active_r;
  assign Next_Bios    = next_r;
  assign Host_Rst_Req = host_r;
  assign Boot_Fail    = fail_r;
  assign Wdt_State    = state_r;

endmodule

// File: tb/tb_bios_boot_watchdog.sv
`timescale 1ns/1ps
// Self-checking bench for bios_boot_watchdog with a cycle-level reference model.
module tb_bios_boot_watchdog;

  localparam int CLK_PER_TICK = 4;
  localparam int BOOT_TIMEOUT = 10;
  localparam int MAX_SWITCH   = 1;
  localparam int RST_PULSE    = 8;
  localparam int S_OFF = 0, S_HOLD = 1, S_BOOT = 2, S_DONE = 3, S_SWITCH = 4, S_DEAD = 5;

  logic       clk = 1'b0;
  logic       Reset, Pwr_ok, PciReset, Next_Bios_latch, Bios_Done, Sw_Sel_Wr, Sw_Sel, Wdt_En;
  logic       Active_Bios, Next_Bios, Host_Rst_Req;
  logic [1:0] Boot_Fail;
  logic [2:0] Wdt_State;

  int n_cmp = 0;
  int n_err = 0;
  int host_hi = 0;
  bit check_en = 1'b0;

  // reference model state
  int     m_st, m_sw, m_timer, m_phase, m_pulse;
  bit     m_act, m_nxt, m_tick, m_pci_prev, m_rise_d;
  bit [1:0] m_fail;
  logic [7:0] got_v, exp_v;

  always #5 clk = ~clk;

  bios_boot_watchdog #(
    .CLK_PER_TICK (CLK_PER_TICK),
    .BOOT_TIMEOUT (BOOT_TIMEOUT),
    .MAX_SWITCH   (MAX_SWITCH),
    .RST_PULSE    (RST_PULSE)
  ) dut (
    .Clk             (clk),
    .Reset           (Reset),
    .Pwr_ok          (Pwr_ok),
    .PciReset        (PciReset),
    .Next_Bios_latch (Next_Bios_latch),
    .Bios_Done       (Bios_Done),
    .Sw_Sel_Wr       (Sw_Sel_Wr),
    .Sw_Sel          (Sw_Sel),
    .Wdt_En          (Wdt_En),
    .Active_Bios     (Active_Bios),
    .Next_Bios       (Next_Bios),
    .Host_Rst_Req    (Host_Rst_Req),
    .Boot_Fail       (Boot_Fail),
    .Wdt_State       (Wdt_State)
  );

  // Reference model: advances once per rising edge from the sampled inputs.
  always @(posedge clk) begin : ref_model
    int ns, nsw, nt, npl;
    bit na, nn, clr, rise_now;
    bit [1:0] nf;
    if (Reset) begin
      m_st = S_OFF; m_act = 1'b0; m_nxt = 1'b0; m_fail = 2'b00; m_sw = 0; m_timer = 0;
      m_phase = 0; m_tick = 1'b0; m_pulse = 0; m_pci_prev = 1'b0; m_rise_d = 1'b0;
    end else begin
      rise_now = PciReset && !m_pci_prev;
      ns = m_st; na = m_act; nn = m_nxt; nf = m_fail; nsw = m_sw; nt = m_timer; npl = m_pulse;
      clr = 1'b0;
      if (!Pwr_ok) begin
        ns = S_OFF; na = 1'b0; nn = 1'b0; nsw = 0; nt = 0; npl = 0;
      end else begin
        if (m_st == S_OFF) ns = S_HOLD;
        else if (m_st == S_HOLD) begin
          if (m_rise_d) begin ns = S_BOOT; na = Next_Bios_latch; nt = 0; clr = 1'b1; end
        end else if (m_st == S_BOOT) begin
          if (!Wdt_En) nt = 0;
          else if (m_tick && m_timer < 65535) nt = m_timer + 1;
          if (Bios_Done) ns = S_DONE;
          else if (Wdt_En && m_timer >= BOOT_TIMEOUT) begin
            nf[m_act] = 1'b1;
            if (m_sw < MAX_SWITCH) begin ns = S_SWITCH; nn = !m_act; nsw = m_sw + 1; npl = RST_PULSE; end
            else ns = S_DEAD;
          end else if (!PciReset) ns = S_HOLD;
        end else if (m_st == S_DONE) begin
          if (!PciReset) ns = S_HOLD;
        end else if (m_st == S_SWITCH) begin
          npl = m_pulse - 1;
          if (npl == 0) ns = S_HOLD;
        end else if (m_st == S_DEAD) begin
          if (m_rise_d) na = Next_Bios_latch;
        end
        if (Sw_Sel_Wr && m_st != S_SWITCH && m_st != S_DEAD && ns != S_SWITCH) nn = Sw_Sel;
      end
      // one tick per CLK_PER_TICK cycles, period restarted on BOOT entry
      if (clr) begin m_phase = 0; m_tick = 1'b0; end
      else if (m_phase == CLK_PER_TICK - 1) begin m_phase = 0; m_tick = 1'b1; end
      else begin m_phase = m_phase + 1; m_tick = 1'b0; end
      m_st = ns; m_act = na; m_nxt = nn; m_fail = nf; m_sw = nsw; m_timer = nt; m_pulse = npl;
      m_rise_d = rise_now; m_pci_prev = PciReset;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (Host_Rst_Req === 1'b1) host_hi = host_hi + 1;
    if (check_en) begin
      got_v = {Active_Bios, Next_Bios, Host_Rst_Req, Boot_Fail, Wdt_State};
      exp_v = {m_act, m_nxt, (m_pulse != 0), m_fail, 3'(m_st)};
      n_cmp = n_cmp + 1;
      if (got_v !== exp_v) begin
        n_err = n_err + 1;
        $display("FAIL cycle_compare t=%0t {act,next,rst,fail,state} got %b expected %b", $time, got_v, exp_v);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int target, input int budget, input string name, output int elapsed);
    elapsed = -1;
    for (int i = 0; i < budget; i++) begin
      if (Wdt_State === 3'(target)) begin
        elapsed = i;
        break;
      end
      step(1);
    end
    n_cmp = n_cmp + 1;
    if (elapsed < 0) begin
      n_err = n_err + 1;
      $display("FAIL %s: state %0d not reached, still %0d after %0d cycles", name, target, Wdt_State, budget);
    end
  endtask

  task automatic wait_timer(input int target, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (m_timer >= target) break;
      step(1);
    end
    n_cmp = n_cmp + 1;
    if (i == budget) begin
      n_err = n_err + 1;
      $display("FAIL %s: model timer %0d never reached %0d", name, m_timer, target);
    end
  endtask

  task automatic pulse_done();
    Bios_Done = 1'b1;
    step(1);
    Bios_Done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int e, h0;
    Reset = 1'b1; Pwr_ok = 1'b0; PciReset = 1'b0; Next_Bios_latch = 1'b0; Bios_Done = 1'b0;
    Sw_Sel_Wr = 1'b0; Sw_Sel = 1'b0; Wdt_En = 1'b1;
    step(2);
    check_en = 1'b1;
    chk("reset_state", 32'(Wdt_State), S_OFF);
    chk("reset_outputs", 32'({Active_Bios, Next_Bios, Host_Rst_Req, Boot_Fail}), 0);

    // 1: normal boot on socket 0
    Reset = 1'b0; Pwr_ok = 1'b1;
    step(2);
    chk("s1_hold", 32'(Wdt_State), S_HOLD);
    PciReset = 1'b1; Next_Bios_latch = 1'b0;
    wait_state(S_BOOT, 10, "s1_boot", e);
    step(5 * CLK_PER_TICK);
    pulse_done();
    step(2);
    chk("s1_done", 32'(Wdt_State), S_DONE);
    chk("s1_active", 32'(Active_Bios), 0);
    chk("s1_fail", 32'(Boot_Fail), 0);
    chk("s1_no_rst", 32'(host_hi), 0);

    // 2: timeout on socket 0 -> switch to socket 1
    PciReset = 1'b0; step(2);
    PciReset = 1'b1; Next_Bios_latch = 1'b0;
    wait_state(S_BOOT, 10, "s2_boot", e);
    h0 = host_hi;
    wait_state(S_SWITCH, 60, "s2_switch", e);
    chk("s2_fail", 32'(Boot_Fail), 1);
    chk("s2_next", 32'(Next_Bios), 1);
    wait_state(S_HOLD, 20, "s2_hold", e);
    chk("s2_pulse_width", 32'(host_hi - h0), RST_PULSE);
    PciReset = 1'b0; step(2);
    PciReset = 1'b1; Next_Bios_latch = 1'b1;
    wait_state(S_BOOT, 10, "s2_boot1", e);
    chk("s2_active1", 32'(Active_Bios), 1);

    // 3: socket 1 also times out -> DEAD, then power cycle
    h0 = host_hi;
    wait_state(S_DEAD, 60, "s3_dead", e);
    chk("s3_fail", 32'(Boot_Fail), 3);
    step(20);
    chk("s3_no_rst", 32'(host_hi - h0), 0);
    chk("s3_still_dead", 32'(Wdt_State), S_DEAD);
    PciReset = 1'b0; step(2);
    Next_Bios_latch = 1'b0; PciReset = 1'b1; step(3);
    chk("s3_dead_active", 32'(Active_Bios), 0);
    Pwr_ok = 1'b0; step(2);
    chk("s3_off", 32'(Wdt_State), S_OFF);
    chk("s3_off_fail", 32'(Boot_Fail), 3);
    Pwr_ok = 1'b1; step(2);
    chk("s3_hold", 32'(Wdt_State), S_HOLD);

    // 5: warm reset at tick 6, then a full restart to timeout
    PciReset = 1'b0; step(2);
    PciReset = 1'b1; Next_Bios_latch = 1'b0;
    wait_state(S_BOOT, 10, "s5_boot", e);
    wait_timer(6, 60, "s5_tick6");
    PciReset = 1'b0; step(2);
    chk("s5_warm_hold", 32'(Wdt_State), S_HOLD);
    chk("s5_no_flag", 32'(Boot_Fail), 3);
    PciReset = 1'b1;
    wait_state(S_BOOT, 10, "s5_boot2", e);
    wait_state(S_SWITCH, 60, "s5_switch", e);
    // ten full tick periods, one cycle to register the tick, one to decide
    chk("s5_timeout_latency", 32'(e), BOOT_TIMEOUT * CLK_PER_TICK + 2);
    wait_state(S_HOLD, 20, "s5_hold", e);

    // 4: Bios_Done in the same cycle as the timeout
    Reset = 1'b1; PciReset = 1'b0; step(2);
    Reset = 1'b0; step(2);
    chk("s4_reset_fail", 32'(Boot_Fail), 0);
    PciReset = 1'b1; Next_Bios_latch = 1'b0;
    wait_state(S_BOOT, 10, "s4_boot", e);
    h0 = host_hi;
    wait_timer(BOOT_TIMEOUT, 60, "s4_at_timeout");
    pulse_done();
    step(2);
    chk("s4_done", 32'(Wdt_State), S_DONE);
    chk("s4_fail", 32'(Boot_Fail), 0);
    chk("s4_no_rst", 32'(host_hi - h0), 0);

    // 6: software select and watchdog disable
    PciReset = 1'b0; step(2);
    chk("s6_next0", 32'(Next_Bios), 0);
    Sw_Sel = 1'b1; Sw_Sel_Wr = 1'b1; step(1);
    Sw_Sel_Wr = 1'b0;
    chk("s6_sw_next", 32'(Next_Bios), 1);
    Wdt_En = 1'b0; PciReset = 1'b1; Next_Bios_latch = 1'b0;
    wait_state(S_BOOT, 10, "s6_boot", e);
    step(20 * CLK_PER_TICK);
    chk("s6_no_timeout", 32'(Wdt_State), S_BOOT);
    chk("s6_timer_zero", 32'(m_timer), 0);
    Wdt_En = 1'b1;
    wait_state(S_SWITCH, 60, "s6_switch", e);
    chk("s6_fail", 32'(Boot_Fail), 1);
    wait_state(S_HOLD, 20, "s6_hold", e);

    // randomized traffic against the model
    Reset = 1'b1; PciReset = 1'b0; step(2);
    Reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      Reset = ($urandom_range(0, 999) == 0);
      if (Pwr_ok) Pwr_ok = ($urandom_range(0, 299) != 0);
      else Pwr_ok = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) PciReset = ~PciReset;
      if (Wdt_En) Wdt_En = ($urandom_range(0, 199) != 0);
      else Wdt_En = ($urandom_range(0, 19) == 0);
      Next_Bios_latch = 1'($urandom_range(0, 1));
      Bios_Done = ($urandom_range(0, 79) == 0);
      Sw_Sel_Wr = ($urandom_range(0, 39) == 0);
      Sw_Sel = 1'($urandom_range(0, 1));
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
